// File: rtl/sram_frame_writer.sv
// sram_frame_writer
//   Turns the delayed capture-window enable, pixel stream and line markers
//   into SRAM write cycles.  Exactly one H_ACTIVE x V_ACTIVE frame is stored
//   per capture window.  Each pixel's address is line_base + pixel offset,
//   and line_base steps by LINE_STRIDE at every line end.
//   All state changes on the falling edge of DDT_Clock.  Reset is
//   asynchronous and active high.
// Ports:
//   DDT_Clock, Reset                  : clock (falling-edge active), async reset
//   Wr_En_n                           : capture window, active low
//   Pix_Data/Pix_Valid                : pixel word and its qualifier
//   Line_Start/Line_End               : line markers (first pixel / cycle after last)
//   Sram_Addr/Data/WE_n/CE_n          : SRAM write interface (registered)
//   Frame_Done, Frame_Abort, Line_Idx : sequencer status
//   Pix_Overflow, Line_Short          : sticky line-geometry errors
module sram_frame_writer #(
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 27,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int LINE_STRIDE = 1024
) (
  input  logic              DDT_Clock,
  input  logic              Reset,
  input  logic              Wr_En_n,
  input  logic [DATA_W-1:0] Pix_Data,
  input  logic              Pix_Valid,
  input  logic              Line_Start,
  input  logic              Line_End,
  output logic [ADDR_W-1:0] Sram_Addr,
  output logic [DATA_W-1:0] Sram_Data,
  output logic              Sram_WE_n,
  output logic              Sram_CE_n,
  output logic              Frame_Done,
  output logic              Frame_Abort,
  output logic [15:0]       Line_Idx,
  output logic              Pix_Overflow,
  output logic              Line_Short
);
  localparam int CW = $clog2(H_ACTIVE + 1);

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [15:0]         idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                we_n_q, we_n_d;
  logic                abort_q, abort_d;
  logic                ovf_q, ovf_d;
  logic                short_q, short_d;

  // Effective counters after any line end taken this cycle; the pixel write
  // (if any) is then applied on top of them.
  logic [CW-1:0]       cnt_v;
  logic [ADDR_W-1:0]   base_v;
  logic                take_pix;

  always_ff @(negedge DDT_Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      pix_cnt_q <= '0;
      base_q    <= '0;
      idx_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      we_n_q    <= 1'b1;
      abort_q   <= 1'b0;
      ovf_q     <= 1'b0;
      short_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      base_q    <= base_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      we_n_q    <= we_n_d;
      abort_q   <= abort_d;
      ovf_q     <= ovf_d;
      short_q   <= short_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_n_d   = 1'b1;
    abort_d  = 1'b0;
    ovf_d    = ovf_q;
    short_d  = short_q;
    cnt_v    = pix_cnt_q;
    base_v   = base_q;
    take_pix = 1'b0;

    case (state_q)
      IDLE: begin
        if (!Wr_En_n) begin
          state_d = ARMED;
          cnt_v   = '0;
          base_v  = '0;
          idx_d   = '0;
          ovf_d   = 1'b0;
          short_d = 1'b0;
        end
      end
      ARMED: begin
        if (Wr_En_n) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (Line_Start) begin
          state_d  = ACTIVE;
          take_pix = Pix_Valid;
        end
      end
      ACTIVE: begin
        if (Wr_En_n) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else begin
          take_pix = Pix_Valid;
          // A Line_Start without a preceding Line_End closes the current line
          // exactly as Line_End would, then opens the next one.
          if (Line_End || Line_Start) begin
            if (pix_cnt_q < CW'(H_ACTIVE)) short_d = 1'b1;
            cnt_v    = '0;
            base_v   = base_q + ADDR_W'(LINE_STRIDE);
            idx_d    = idx_q + 16'd1;
            take_pix = Pix_Valid && Line_Start;
            if (idx_q == 16'(V_ACTIVE - 1)) begin
              state_d  = DONE;
              take_pix = 1'b0;
            end else if (!Line_Start) begin
              state_d = ARMED;
            end
          end
        end
      end
      DONE: begin
        if (Wr_En_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (take_pix) begin
      if (cnt_v < CW'(H_ACTIVE)) begin
        addr_d = base_v + ADDR_W'(cnt_v);
        data_d = Pix_Data;
        we_n_d = 1'b0;
        cnt_v  = cnt_v + CW'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end

    pix_cnt_d = cnt_v;
    base_d    = base_v;
  end

  assign Sram_Addr    = addr_q;
  assign Sram_Data    = data_q;
  assign Sram_WE_n    = we_n_q;
  assign Sram_CE_n    = !(state_q == ARMED || state_q == ACTIVE);
  assign Frame_Done   = (state_q == DONE);
  assign Frame_Abort  = abort_q;
  assign Line_Idx     = idx_q;
  assign Pix_Overflow = ovf_q;
  assign Line_Short   = short_q;
endmodule

// File: tb/tb_sram_frame_writer.sv
module tb_sram_frame_writer;
  localparam int AW = 19;
  localparam int DW = 27;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wen_n = 1'b1;
  logic [DW-1:0] pdata = '0;
  logic          pvld = 1'b0;
  logic          ls = 1'b0;
  logic          le = 1'b0;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          we_n, ce_n, done, abort, ovf, shrt;
  logic [15:0]   lidx;

  int vec = 0;
  int errs = 0;

  logic [AW-1:0] qa[$];
  logic [DW-1:0] qd[$];

  sram_frame_writer #(.ADDR_W(AW), .DATA_W(DW), .H_ACTIVE(4), .V_ACTIVE(3), .LINE_STRIDE(8)) dut (
    .DDT_Clock(clk), .Reset(rst), .Wr_En_n(wen_n), .Pix_Data(pdata), .Pix_Valid(pvld),
    .Line_Start(ls), .Line_End(le), .Sram_Addr(addr), .Sram_Data(data), .Sram_WE_n(we_n),
    .Sram_CE_n(ce_n), .Frame_Done(done), .Frame_Abort(abort), .Line_Idx(lidx),
    .Pix_Overflow(ovf), .Line_Short(shrt)
  );

  always #5 clk = ~clk;

  // Log every write strobe mid-cycle, away from the active falling edge.
  always @(posedge clk) begin
    if (we_n === 1'b0) begin
      qa.push_back(addr);
      qd.push_back(data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Advance past one active (falling) edge; outputs are stable afterwards.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_line(input int n, input logic [DW-1:0] d0, input bit end_pulse);
    for (int k = 0; k < n; k++) begin
      ls = (k == 0); pvld = 1'b1; pdata = d0 + DW'(k);
      step();
    end
    ls = 1'b0; pvld = 1'b0;
    if (end_pulse) begin
      le = 1'b1; step(); le = 1'b0;
    end
  endtask

  task automatic clear_log();
    qa.delete(); qd.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; #23;
    vec++;
    if (addr !== '0 || data !== '0 || we_n !== 1'b1 || ce_n !== 1'b1 || done !== 1'b0 ||
        abort !== 1'b0 || lidx !== 16'd0 || ovf !== 1'b0 || shrt !== 1'b0) begin
      errs++;
      $display("FAIL reset_values: addr=%0h data=%0h we_n=%b ce_n=%b done=%b abort=%b idx=%0d ovf=%b short=%b, want all idle",
               addr, data, we_n, ce_n, done, abort, lidx, ovf, shrt);
    end
    @(posedge clk); rst = 1'b0;
    step();
  endtask

  task automatic test_nominal();
    wen_n = 1'b0; step();
    vec++;
    if (ce_n !== 1'b0) begin errs++; $display("FAIL nominal_armed_ce: got %b want 0", ce_n); end
    for (int l = 0; l < 3; l++) begin
      for (int k = 0; k < 4; k++) begin
        ls = (k == 0); pvld = 1'b1; pdata = DW'(32'h10 + l*4 + k);
        step();
        vec++;
        if (we_n !== 1'b0 || addr !== AW'(l*8 + k) || data !== DW'(32'h10 + l*4 + k)) begin
          errs++;
          $display("FAIL nominal_write l%0d p%0d: we_n=%b addr=%0d data=%0h want 0 %0d %0h",
                   l, k, we_n, addr, data, l*8 + k, 32'h10 + l*4 + k);
        end
      end
      ls = 1'b0; pvld = 1'b0; le = 1'b1; step(); le = 1'b0;
      vec++;
      if (we_n !== 1'b1 || lidx !== 16'(l + 1)) begin
        errs++; $display("FAIL nominal_line_end l%0d: we_n=%b idx=%0d want 1 %0d", l, we_n, lidx, l + 1);
      end
    end
    vec++;
    if (done !== 1'b1 || ce_n !== 1'b1 || ovf !== 1'b0 || shrt !== 1'b0) begin
      errs++; $display("FAIL nominal_done: done=%b ce_n=%b ovf=%b short=%b want 1 1 0 0", done, ce_n, ovf, shrt);
    end
    wen_n = 1'b1; step();
    vec++;
    if (done !== 1'b0) begin errs++; $display("FAIL nominal_release: done=%b want 0", done); end
  endtask

  task automatic test_overflow_short();
    logic [AW-1:0] ea[10];
    logic [DW-1:0] ed[10];
    ea = '{0, 1, 2, 3, 8, 9, 16, 17, 18, 19};
    ed = '{'h20, 'h21, 'h22, 'h23, 'h30, 'h31, 'h40, 'h41, 'h42, 'h43};
    clear_log();
    wen_n = 1'b0; step();
    send_line(6, 'h20, 1);
    vec++;
    if (ovf !== 1'b1 || shrt !== 1'b0) begin
      errs++; $display("FAIL ovf_after_line0: ovf=%b short=%b want 1 0", ovf, shrt);
    end
    send_line(2, 'h30, 1);
    send_line(4, 'h40, 1);
    vec++;
    if (qa.size() != 10) begin
      errs++; $display("FAIL ovf_write_count: got %0d want 10", qa.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        vec++;
        if (qa[i] !== ea[i] || qd[i] !== ed[i]) begin
          errs++; $display("FAIL ovf_write_%0d: addr=%0d data=%0h want %0d %0h", i, qa[i], qd[i], ea[i], ed[i]);
        end
      end
    end
    vec++;
    if (ovf !== 1'b1 || shrt !== 1'b1 || done !== 1'b1) begin
      errs++; $display("FAIL ovf_flags: ovf=%b short=%b done=%b want 1 1 1", ovf, shrt, done);
    end
    wen_n = 1'b1; step();
  endtask

  task automatic test_abort();
    clear_log();
    wen_n = 1'b0; step();
    send_line(5, 'h50, 1);
    send_line(2, 'h60, 0);
    wen_n = 1'b1; pvld = 1'b1; pdata = 'h62; step();
    vec++;
    if (abort !== 1'b1 || we_n !== 1'b1 || ce_n !== 1'b1) begin
      errs++; $display("FAIL abort_pulse: abort=%b we_n=%b ce_n=%b want 1 1 1", abort, we_n, ce_n);
    end
    pdata = 'h63; step();
    vec++;
    if (abort !== 1'b0) begin errs++; $display("FAIL abort_one_cycle: abort=%b want 0", abort); end
    pvld = 1'b0; step();
    vec++;
    if (qa.size() != 6 || ovf !== 1'b1) begin
      errs++; $display("FAIL abort_writes_sticky: writes=%0d ovf=%b want 6 1", qa.size(), ovf);
    end
    wen_n = 1'b0; step();
    vec++;
    if (ovf !== 1'b0 || shrt !== 1'b0 || lidx !== 16'd0) begin
      errs++; $display("FAIL abort_rearm_clear: ovf=%b short=%b idx=%0d want 0 0 0", ovf, shrt, lidx);
    end
    ls = 1'b1; pvld = 1'b1; pdata = 'h70; step(); ls = 1'b0; pvld = 1'b0;
    vec++;
    if (we_n !== 1'b0 || addr !== AW'(0) || data !== DW'('h70)) begin
      errs++; $display("FAIL abort_rearm_addr: we_n=%b addr=%0d data=%0h want 0 0 70", we_n, addr, data);
    end
    wen_n = 1'b1; step(); step();
  endtask

  task automatic test_missing_line_end();
    wen_n = 1'b0; step();
    send_line(4, 'h80, 0);
    ls = 1'b1; pvld = 1'b1; pdata = 'h90; step(); ls = 1'b0; pvld = 1'b0;
    vec++;
    if (we_n !== 1'b0 || addr !== AW'(8) || data !== DW'('h90) || lidx !== 16'd1 || shrt !== 1'b0) begin
      errs++; $display("FAIL missing_le: we_n=%b addr=%0d data=%0h idx=%0d short=%b want 0 8 90 1 0",
                       we_n, addr, data, lidx, shrt);
    end
    wen_n = 1'b1; step(); step();
  endtask

  task automatic test_one_frame_per_window();
    clear_log();
    wen_n = 1'b0; step();
    send_line(4, 'hA0, 1);
    send_line(4, 'hA4, 1);
    send_line(4, 'hA8, 1);
    vec++;
    if (done !== 1'b1 || qa.size() != 12) begin
      errs++; $display("FAIL window_frame: done=%b writes=%0d want 1 12", done, qa.size());
    end
    send_line(4, 'hB0, 1);
    send_line(4, 'hB4, 1);
    vec++;
    if (qa.size() != 12 || done !== 1'b1) begin
      errs++; $display("FAIL window_no_rearm: writes=%0d done=%b want 12 1", qa.size(), done);
    end
    wen_n = 1'b1; step();
    vec++;
    if (done !== 1'b0) begin errs++; $display("FAIL window_release: done=%b want 0", done); end
    wen_n = 1'b0; step();
    ls = 1'b1; pvld = 1'b1; pdata = 'hC0; step(); ls = 1'b0; pvld = 1'b0;
    vec++;
    if (we_n !== 1'b0 || addr !== AW'(0) || data !== DW'('hC0)) begin
      errs++; $display("FAIL window_recapture: we_n=%b addr=%0d data=%0h want 0 0 c0", we_n, addr, data);
    end
    wen_n = 1'b1; step(); step();
  endtask

  task automatic test_reset_mid_line();
    wen_n = 1'b0; step();
    send_line(4, 'hD0, 1);
    send_line(3, 'hE0, 0);
    vec++;
    if (we_n !== 1'b0 || addr !== AW'(10)) begin
      errs++; $display("FAIL midreset_pre: we_n=%b addr=%0d want 0 10", we_n, addr);
    end
    #2 rst = 1'b1;
    #1;
    vec++;
    if (we_n !== 1'b1 || ce_n !== 1'b1 || addr !== '0 || data !== '0 || lidx !== 16'd0 ||
        done !== 1'b0 || abort !== 1'b0) begin
      errs++; $display("FAIL midreset_async: we_n=%b ce_n=%b addr=%0d data=%0h idx=%0d done=%b abort=%b want 1 1 0 0 0 0 0",
                       we_n, ce_n, addr, data, lidx, done, abort);
    end
    @(posedge clk); rst = 1'b0;
    step();
    ls = 1'b1; pvld = 1'b1; pdata = 'hF0; step(); ls = 1'b0; pvld = 1'b0;
    vec++;
    if (we_n !== 1'b0 || addr !== AW'(0) || data !== DW'('hF0)) begin
      errs++; $display("FAIL midreset_restart: we_n=%b addr=%0d data=%0h want 0 0 f0", we_n, addr, data);
    end
    wen_n = 1'b1; step(); step();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_overflow_short();
    test_abort();
    test_missing_line_end();
    test_one_frame_per_window();
    test_reset_mid_line();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/sram_frame_writer.md
Name: sram_frame_writer

Overview:
Downstream stage of the SRAM capture control block. Consumes the delayed, active-low frame-capture write enable, the delayed 27-bit pixel word and the DE-derived line markers, and converts them into SRAM write cycles. It generates per-pixel addresses from a line base plus pixel offset, stores exactly one frame of H_ACTIVE x V_ACTIVE pixels, and reports completion and geometry errors to the frame sequencer.

Parameters:
ADDR_W, 19, SRAM address width.
DATA_W, 27, pixel word width. Passed through unchanged.
H_ACTIVE, 640, pixels written per line. Extra pixels are dropped.
V_ACTIVE, 480, lines written per frame.
LINE_STRIDE, 1024, address increment between line bases. Must be >= H_ACTIVE.

Ports:
DDT_Clock  in  1  pixel clock. All registers update on its falling edge.
Reset  in  1  asynchronous, active-high reset.
Wr_En_n  in  1  frame capture window, active low (delayed WE from capture control).
Pix_Data  in  DATA_W  pixel word, aligned with Pix_Valid.
Pix_Valid  in  1  pixel qualifier (DE aligned to Pix_Data).
Line_Start  in  1  one-cycle pulse coincident with the first Pix_Valid of a line.
Line_End  in  1  one-cycle pulse in the cycle after the last Pix_Valid of a line.
Sram_Addr  out  ADDR_W  write address.
Sram_Data  out  DATA_W  write data.
Sram_WE_n  out  1  SRAM write strobe, active low.
Sram_CE_n  out  1  SRAM chip enable, active low.
Frame_Done  out  1  level: V_ACTIVE lines stored.
Frame_Abort  out  1  one-cycle pulse: capture window closed mid-frame.
Line_Idx  out  16  index of the line currently being written.
Pix_Overflow  out  1  sticky: a line carried more than H_ACTIVE valid pixels.
Line_Short  out  1  sticky: a line ended with fewer than H_ACTIVE pixels.

Behaviour:
- Reset values: Sram_Addr=0, Sram_Data=0, Sram_WE_n=1, Sram_CE_n=1, Frame_Done=0, Frame_Abort=0, Line_Idx=0, both sticky flags 0, FSM=IDLE.
- Internal state: pix_cnt (width clog2(H_ACTIVE+1)) and line_base (ADDR_W). line_base advances by adding LINE_STRIDE; no multiplier is used.
- FSM states are IDLE, ARMED, ACTIVE and DONE.
- IDLE: Sram_CE_n=1. When Wr_En_n=0, go to ARMED and clear line_base, Line_Idx, pix_cnt and both sticky flags.
- ARMED: Sram_CE_n=0. On Line_Start, go to ACTIVE. If Pix_Valid is also set that cycle, pixel 0 is written.
- ACTIVE, write rule: on each cycle with Pix_Valid=1 and pix_cnt<H_ACTIVE, the next edge registers Sram_Addr=line_base+pix_cnt, Sram_Data=Pix_Data and Sram_WE_n=0, and pix_cnt increments. Latency from input sample to output is 1 cycle.
- ACTIVE, non-write cycles: Sram_WE_n=1. Sram_Addr and Sram_Data hold their last values.
- ACTIVE, overflow: Pix_Valid=1 with pix_cnt==H_ACTIVE performs no write and sets Pix_Overflow.
- ACTIVE, Line_End: if pix_cnt<H_ACTIVE, set Line_Short. Then clear pix_cnt, add LINE_STRIDE to line_base and increment Line_Idx. If Line_Idx was V_ACTIVE-1, go to DONE, otherwise go to ARMED.
- ACTIVE, Line_Start without a preceding Line_End: treat it as a Line_End (same counter and flag updates) followed by a new line start. Stay in ACTIVE; a coincident Pix_Valid is written as pixel 0 of the new line. If that implicit end completes the frame, go to DONE and ignore the pixel.
- Simultaneous Line_End and Line_Start: Line_End is processed first, then Line_Start. The result is identical to the case above.
- Abort: Wr_En_n=1 in ARMED or ACTIVE sends the FSM to IDLE next edge, with Frame_Abort high for one cycle, Sram_WE_n=1 and Sram_CE_n=1. The sticky flags are retained until the next arm. Abort has priority over any write in that cycle.
- DONE: Frame_Done=1, Sram_WE_n=1, Sram_CE_n=1. All inputs are ignored until Wr_En_n=1, then go to IDLE and clear Frame_Done. The FSM never re-arms while Wr_En_n stays low, so exactly one frame is stored per window.
- Address arithmetic is modulo 2^ADDR_W. Wrap-around is not flagged; the integrator sizes the parameters.
- Reset asserted mid-frame forces all reset values immediately, with Sram_WE_n=1 asynchronously.

Test Plan:
Test parameters for all scenarios: H_ACTIVE=4, V_ACTIVE=3, LINE_STRIDE=8.
1. Nominal frame: Wr_En_n=0, then 3 lines of 4 valid pixels with data 0x10+k -> writes at addresses 0-3, 8-11 and 16-19 with matching data, one cycle after each Pix_Valid. Frame_Done=1 after the third Line_End; no flags set.
2. Overflow and short line: line 0 carries 6 pixels and line 1 carries 2 -> only addresses 0-3 and 8-9 are written. Pix_Overflow=1 and Line_Short=1; line 2 is written at 16-19.
3. Abort: Wr_En_n returns to 1 after pixel 1 of line 1 -> Frame_Abort pulses once and no further Sram_WE_n=0 occurs. A re-arm restarts at address 0 with flags cleared.
4. Missing Line_End: Line_Start arrives directly after the 4th pixel of line 0 -> the next pixel is written to address 8 and Line_Idx=1.
5. One frame per window: hold Wr_En_n=0 after Frame_Done and drive further lines -> no writes occur. Releasing Wr_En_n clears Frame_Done; re-asserting it captures again from address 0.
6. Reset mid-line at pixel 2 of line 1 -> all outputs take their reset values immediately. After release with Wr_En_n=0, the next Line_Start writes at address 0.
